// File: rtl/ula_controle_mc_pkg.sv
// Shared definitions for the ULA control FSM: ULA operation codes,
// MIPS opcodes understood by the controller, and the FSM state set.
package ula_controle_mc_pkg;

    // ULA operation selector (inputULA), shared with the ULA itself
    localparam logic [1:0] LOAD               = 2'b00;
    localparam logic [1:0] BRANCH             = 2'b01;
    localparam logic [1:0] ADD_SUB_AND_OR_SLT = 2'b10;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // Controller states; *_W states wait out the ULA's registered latency
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_EXEC_W = 4'd3,
        S_ADDR   = 4'd4,
        S_ADDR_W = 4'd5,
        S_MEM    = 4'd6,
        S_WB     = 4'd7,
        S_BR     = 4'd8,
        S_BR_W   = 4'd9,
        S_RET    = 4'd10,
        S_ERR    = 4'd11
    } state_t;

endpackage

// File: rtl/ula_controle_mc_if.sv
// Bundle of the instruction handshake, ULA drive/result, memory and
// retirement strobes. master = controller side, slave = environment.
interface ula_controle_mc_if #(parameter int DATA_W = 32);
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic              instr_ready;
    logic [1:0]        alu_op;
    logic [5:0]        alu_funct;
    logic              alu_b_imm;
    logic [DATA_W-1:0] alu_result;
    logic              mem_req;
    logic              mem_we;
    logic              mem_ack;
    logic              reg_we;
    logic              reg_dst_rd;
    logic              pc_we;
    logic              branch_taken;
    logic              done;
    logic              error;

    modport master (
        input  instr_valid, instr, alu_result, mem_ack,
        output instr_ready, alu_op, alu_funct, alu_b_imm, mem_req, mem_we,
               reg_we, reg_dst_rd, pc_we, branch_taken, done, error
    );

    modport slave (
        output instr_valid, instr, alu_result, mem_ack,
        input  instr_ready, alu_op, alu_funct, alu_b_imm, mem_req, mem_we,
               reg_we, reg_dst_rd, pc_we, branch_taken, done, error
    );
endinterface

// File: rtl/ula_controle_mc_decode.sv
// Combinational opcode classifier for the ULA control FSM.
module ula_controle_mc_decode
    import ula_controle_mc_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       is_rtype,
    output logic       is_mem,
    output logic       is_store,
    output logic       is_beq,
    output logic       illegal
);

    // Classify the latched opcode; anything unrecognised is illegal
    always_comb begin
        is_rtype = 1'b0;
        is_mem   = 1'b0;
        is_store = 1'b0;
        is_beq   = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: is_rtype = 1'b1;
            OP_LW:    is_mem   = 1'b1;
            OP_SW: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_BEQ:   is_beq   = 1'b1;
            default:  illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/ula_controle_mc.sv
// Multicycle control FSM in front of the ULA: accepts one instruction per
// handshake, sequences the ULA operation, memory access and write-back,
// and emits PC/retire/error strobes.
module ula_controle_mc
    import ula_controle_mc_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    ula_controle_mc_if.master   bus
);

    localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [5:0] opcode_r;
    logic [5:0] funct_r;
    logic [3:0] tmo_cnt_r;

    logic       instr_ready_r;
    logic [1:0] alu_op_r;
    logic       alu_b_imm_r;
    logic       mem_req_r;
    logic       mem_we_r;
    logic       reg_we_r;
    logic       reg_dst_rd_r;
    logic       pc_we_r;
    logic       done_r;
    logic       error_r;

    logic       dec_rtype_s;
    logic       dec_mem_s;
    logic       dec_store_s;
    logic       dec_beq_s;
    logic       dec_illegal_s;
    logic       handshake_s;
    logic       result_zero_s;
    logic       unused_instr_s;

    ula_controle_mc_decode u_decode (
        .opcode   (opcode_r),
        .is_rtype (dec_rtype_s),
        .is_mem   (dec_mem_s),
        .is_store (dec_store_s),
        .is_beq   (dec_beq_s),
        .illegal  (dec_illegal_s)
    );

    assign handshake_s    = bus.instr_valid & instr_ready_r;
    assign result_zero_s  = (bus.alu_result == {DATA_W{1'b0}});
    assign unused_instr_s = ^bus.instr[25:6];

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (handshake_s) state_nxt_s = S_DECODE;
                else             state_nxt_s = S_FETCH;
            end
            S_DECODE: begin
                if (dec_illegal_s)    state_nxt_s = S_ERR;
                else if (dec_rtype_s) state_nxt_s = S_EXEC;
                else if (dec_mem_s)   state_nxt_s = S_ADDR;
                else if (dec_beq_s)   state_nxt_s = S_BR;
                else                  state_nxt_s = S_ERR;
            end
            S_EXEC:   state_nxt_s = S_EXEC_W;
            S_EXEC_W: state_nxt_s = S_WB;
            S_ADDR:   state_nxt_s = S_ADDR_W;
            S_ADDR_W: state_nxt_s = S_MEM;
            S_MEM: begin
                if (bus.mem_ack) begin
                    if (dec_store_s) state_nxt_s = S_RET;
                    else             state_nxt_s = S_WB;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_nxt_s = S_ERR;
                end else begin
                    state_nxt_s = S_MEM;
                end
            end
            S_WB:     state_nxt_s = S_RET;
            S_BR:     state_nxt_s = S_BR_W;
            S_BR_W:   state_nxt_s = S_FETCH;
            S_RET:    state_nxt_s = S_FETCH;
            S_ERR:    state_nxt_s = S_FETCH;
            default:  state_nxt_s = S_FETCH;
        endcase
    end

    // State register plus Moore outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_FETCH;
            instr_ready_r <= 1'b1;
            alu_op_r      <= LOAD;
            alu_b_imm_r   <= 1'b0;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            reg_we_r      <= 1'b0;
            reg_dst_rd_r  <= 1'b0;
            pc_we_r       <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            instr_ready_r <= 1'b0;
            alu_op_r      <= LOAD;
            alu_b_imm_r   <= 1'b0;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            reg_we_r      <= 1'b0;
            reg_dst_rd_r  <= 1'b0;
            pc_we_r       <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
            case (state_nxt_s)
                S_FETCH:          instr_ready_r <= 1'b1;
                S_EXEC, S_EXEC_W: alu_op_r      <= ADD_SUB_AND_OR_SLT;
                S_ADDR, S_ADDR_W: alu_b_imm_r   <= 1'b1;
                S_MEM: begin
                    mem_req_r <= 1'b1;
                    mem_we_r  <= dec_store_s;
                end
                S_WB: begin
                    reg_we_r     <= 1'b1;
                    reg_dst_rd_r <= dec_rtype_s;
                end
                S_BR:             alu_op_r      <= BRANCH;
                S_BR_W: begin
                    alu_op_r <= BRANCH;
                    done_r   <= 1'b1;
                end
                S_RET: begin
                    pc_we_r <= 1'b1;
                    done_r  <= 1'b1;
                end
                S_ERR: begin
                    pc_we_r <= 1'b1;
                    error_r <= 1'b1;
                end
                default:          instr_ready_r <= 1'b0;
            endcase
        end
    end

    // Latch opcode and funct on the accepting edge only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_r <= 6'd0;
            funct_r  <= 6'd0;
        end else if (handshake_s) begin
            opcode_r <= bus.instr[31:26];
            funct_r  <= bus.instr[5:0];
        end else begin
            opcode_r <= opcode_r;
            funct_r  <= funct_r;
        end
    end

    // Memory wait counter: counts cycles spent in MEM, zero everywhere else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= 4'd0;
        end else if (state_r == S_MEM) begin
            tmo_cnt_r <= tmo_cnt_r + 4'd1;
        end else begin
            tmo_cnt_r <= 4'd0;
        end
    end

    // The branch decision needs the ULA result that becomes valid in BR_W,
    // so the taken/not-taken strobes are resolved in that same cycle.
    assign bus.branch_taken = (state_r == S_BR_W) &  result_zero_s;
    assign bus.pc_we        = pc_we_r | ((state_r == S_BR_W) & ~result_zero_s);

    assign bus.instr_ready  = instr_ready_r;
    assign bus.alu_op       = alu_op_r;
    assign bus.alu_funct    = funct_r;
    assign bus.alu_b_imm    = alu_b_imm_r;
    assign bus.mem_req      = mem_req_r;
    assign bus.mem_we       = mem_we_r;
    assign bus.reg_we       = reg_we_r;
    assign bus.reg_dst_rd   = reg_dst_rd_r;
    assign bus.done         = done_r;
    assign bus.error        = error_r;

endmodule

// File: tb/tb_ula_controle_mc.sv
// Directed, table-driven bench for ula_controle_mc plus hand-written
// reset and stray-ack sequences.
module tb_ula_controle_mc;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ula_controle_mc_if bus ();

    ula_controle_mc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] res;
        int ack_at;    // cycle in which mem_ack is high (0 = never)
        int stray;     // pulse mem_ack while idle in FETCH first
        int end_c;     // cycle of done/error
        int kind;      // 1 = done, 2 = error
        int op2;       // alu_op in cycle 2
        int imm2;      // alu_b_imm in cycle 2
        int opcnt;     // cycles with alu_op != 00
        int regwe_at;  // cycle of reg_we (0 = never)
        int dst;       // reg_dst_rd while reg_we
        int memreq;    // cycles with mem_req
        int memwe;     // mem_we seen while mem_req
        int br;        // branch_taken pulses
        int pcwe;      // pc_we pulses
        int funct;     // alu_funct after handshake
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int end_c, kind, op2, imm2, opcnt, regwe_at, dst, memreq, memwe;
        int br, pcwe, excl_bad, funct;
        end_c = -1; kind = 0; op2 = -1; imm2 = -1; opcnt = 0; regwe_at = 0;
        dst = 0; memreq = 0; memwe = 0; br = 0; pcwe = 0; excl_bad = 0; funct = -1;
        @(negedge clk);
        if (v.stray != 0) begin
            bus.mem_ack = 1'b1;
            @(negedge clk);
            bus.mem_ack = 1'b0;
        end
        chk($sformatf("v%0d ready_before", idx), int'(bus.instr_ready), 1);
        bus.instr       = v.instr;
        bus.alu_result  = v.res;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'hFFFF_FFFF;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) funct = int'(bus.alu_funct);
            if (c == 2) begin
                op2  = int'(bus.alu_op);
                imm2 = int'(bus.alu_b_imm);
            end
            if (bus.alu_op != 2'b00) opcnt++;
            if (bus.reg_we) begin
                regwe_at = c;
                dst      = int'(bus.reg_dst_rd);
            end
            if (bus.mem_req) begin
                memreq++;
                if (bus.mem_we) memwe = 1;
            end
            if (bus.branch_taken) br++;
            if (bus.pc_we) pcwe++;
            if ((bus.pc_we && bus.branch_taken) || (bus.done && bus.error)) excl_bad = 1;
            if (bus.done || bus.error) begin
                end_c = c;
                kind  = bus.done ? 1 : 2;
                break;
            end
            bus.mem_ack = (c == v.ack_at) ? 1'b1 : 1'b0;
        end
        bus.mem_ack = 1'b0;
        chk($sformatf("v%0d end_cycle", idx), end_c, v.end_c);
        chk($sformatf("v%0d end_kind", idx), kind, v.kind);
        chk($sformatf("v%0d alu_op_c2", idx), op2, v.op2);
        chk($sformatf("v%0d alu_b_imm_c2", idx), imm2, v.imm2);
        chk($sformatf("v%0d alu_op_cycles", idx), opcnt, v.opcnt);
        chk($sformatf("v%0d reg_we_cycle", idx), regwe_at, v.regwe_at);
        chk($sformatf("v%0d reg_dst_rd", idx), dst, v.dst);
        chk($sformatf("v%0d mem_req_cycles", idx), memreq, v.memreq);
        chk($sformatf("v%0d mem_we", idx), memwe, v.memwe);
        chk($sformatf("v%0d branch_taken", idx), br, v.br);
        chk($sformatf("v%0d pc_we_pulses", idx), pcwe, v.pcwe);
        chk($sformatf("v%0d alu_funct", idx), funct, v.funct);
        chk($sformatf("v%0d exclusive_strobes", idx), excl_bad, 0);
        @(negedge clk);
        chk($sformatf("v%0d ready_after", idx), int'(bus.instr_ready), 1);
        chk($sformatf("v%0d done_after", idx), int'(bus.done | bus.error), 0);
    endtask

    initial begin
        int strobes;
        checks = 0;
        errors = 0;
        //          instr          res    ack st end kd op imm oc rwe dst mrq mwe br pcw funct
        vecs[0] = '{32'h012A4020, 32'd0, 2, 0, 5,  1, 2, 0, 2, 4,  1,  0,  0,  0, 1,  32'h20};
        vecs[1] = '{32'h8D090004, 32'd0, 6, 0, 8,  1, 0, 1, 0, 7,  0,  3,  0,  0, 1,  32'h04};
        vecs[2] = '{32'h11090003, 32'd0, 0, 0, 3,  1, 1, 0, 2, 0,  0,  0,  0,  1, 0,  32'h03};
        vecs[3] = '{32'h11090003, 32'd5, 0, 0, 3,  1, 1, 0, 2, 0,  0,  0,  0,  0, 1,  32'h03};
        vecs[4] = '{32'hAD090008, 32'd0, 0, 0, 19, 2, 0, 1, 0, 0,  0,  15, 1,  0, 1,  32'h08};
        vecs[5] = '{32'hFC000000, 32'd0, 0, 1, 2,  2, 0, 0, 0, 0,  0,  0,  0,  0, 1,  32'h00};
        vecs[6] = '{32'hAD090008, 32'd0, 5, 0, 6,  1, 0, 1, 0, 0,  0,  2,  1,  0, 1,  32'h08};
        vecs[7] = '{32'h012A4022, 32'd0, 0, 0, 5,  1, 2, 0, 2, 4,  1,  0,  0,  0, 1,  32'h22};

        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.alu_result  = 32'd0;
        bus.mem_ack     = 1'b0;
        rst_n           = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst instr_ready", int'(bus.instr_ready), 1);
        chk("rst alu_op", int'(bus.alu_op), 0);
        chk("rst other_outputs", int'({bus.alu_b_imm, bus.mem_req, bus.mem_we, bus.reg_we,
            bus.reg_dst_rd, bus.pc_we, bus.branch_taken, bus.done, bus.error}), 0);
        chk("rst alu_funct", int'(bus.alu_funct), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset in the middle of an lw memory phase
        @(negedge clk);
        bus.instr       = 32'h8D090004;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst mem_req_before", int'(bus.mem_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst mem_req_async", int'(bus.mem_req), 0);
        chk("midrst ready_in_reset", int'(bus.instr_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        strobes = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done || bus.error || bus.pc_we || bus.reg_we || bus.mem_req) strobes++;
        end
        chk("midrst no_strobes", strobes, 0);
        chk("midrst ready_after", int'(bus.instr_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
